// File: rtl/intr_ctrl.sv
// Trap-entry sequencer: edge-latched IRQs, enable mask, arbitration, non-nesting ISR.
// Define INTC_ROUND_ROBIN_EN for round-robin arbitration (fixed lowest-index otherwise).
module intr_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic               EN_WE,
    input  logic [NUM_SRC-1:0] EN_WD,
    input  logic               MIE,
    input  logic               INSTR_DONE,
    input  logic               MRET,
    output logic               INT_TAKEN,
    output logic [ID_W-1:0]    INT_ID,
    output logic               IN_ISR,
    output logic [NUM_SRC-1:0] PENDING,
    output logic [NUM_SRC-1:0] IRQ_EN
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAKE = 2'd1,
        ISR  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    win;
    logic               found;
    logic               grant;

    assign rise     = IRQ & ~irq_q;
    assign eligible = PENDING & IRQ_EN;

`ifdef INTC_ROUND_ROBIN_EN
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_nx;
    logic [NUM_SRC-1:0] rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;

    // Rotate so rr_ptr lands on bit 0, pick lowest, then rotate back
    always_comb begin
        rot   = NUM_SRC'({eligible, eligible} >> rr_ptr);
        off   = '0;
        found = |eligible;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ID_W'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (ID_W+1)'(NUM_SRC)) begin
            sum = sum - (ID_W+1)'(NUM_SRC);
        end
        win   = sum[ID_W-1:0];
        rr_nx = (win == ID_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= rr_nx;
        end
    end
`else
    always_comb begin
        win   = '0;
        found = |eligible;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                win = ID_W'(k);
            end
        end
    end
`endif

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        unique case (state)
            IDLE: begin
                if (INSTR_DONE && MIE && found) begin
                    state_nx = TAKE;
                    grant    = 1'b1;
                end
            end
            TAKE: state_nx = ISR;
            ISR: begin
                if (MRET) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign clr = grant ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << win) : '0;

    // A fresh edge on the winner overrides its clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            irq_q   <= '0;
            PENDING <= '0;
            IRQ_EN  <= '0;
            INT_ID  <= '0;
        end else begin
            state   <= state_nx;
            irq_q   <= IRQ;
            PENDING <= (PENDING & ~clr) | rise;
            if (EN_WE) begin
                IRQ_EN <= EN_WD;
            end
            if (grant) begin
                INT_ID <= win;
            end
        end
    end

    assign INT_TAKEN = (state == TAKE);
    assign IN_ISR    = (state == TAKE) || (state == ISR);

endmodule
